prbs_test_ctrl: RTL
===================

PRBS_TEST_CTRL -- requirements
Module: prbs_test_ctrl

Interface
REQ-001 Parameter PATT_WIDTH, default 8, byte width of output stream.
REQ-002 Parameter REP_WIDTH, default 5, width of header repeat count n.
REQ-003 Parameter LEN_WIDTH, default 8, width of PRBS payload length.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 arst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a test frame; sampled only in IDLE.
REQ-007 abort  input  1  synchronous abort of a running frame.
REQ-008 n  input  REP_WIDTH  number of 0x0A,0x0B,0x0C,0x0D header groups; latched on accepted start.
REQ-009 prbs_len  input  LEN_WIDTH  number of PRBS payload bytes; latched on accepted start.
REQ-010 prbs_byte  input  PATT_WIDTH  current byte from the PRBS-15 generator.
REQ-011 prbs_en  output  1  combinational; high in every cycle whose closing edge captures prbs_byte, generator advances on that same edge.
REQ-012 byte_out  output  PATT_WIDTH  registered stream byte feeding pattern_detector.
REQ-013 byte_valid  output  1  registered; high when byte_out carries a frame byte.
REQ-014 busy  output  1  registered; high in HDR and PAY states.
REQ-015 done  output  1  registered one-cycle pulse at normal frame completion.
REQ-016 err  output  1  registered one-cycle pulse when start is rejected.

Function
REQ-017 FSM states IDLE, HDR, PAY, DONE; unused encodings SHALL return to IDLE.
REQ-018 IDLE: start=1 and n!=0 -> HDR, latch n/prbs_len, byte_out<=0x0A, byte_valid<=1 on that edge (first byte visible one cycle after start).
REQ-019 IDLE: start=1 and n==0 -> stay IDLE, err pulses 1 cycle, no byte_valid.
REQ-020 HDR: byte index cycles 0x0A,0x0B,0x0C,0x0D, one byte per cycle, byte_valid continuously high; exactly 4*n header bytes emitted.
REQ-021 Group counter SHALL count completed groups 0..n-1 without wrap; n=2^REP_WIDTH-1 SHALL be supported.
REQ-022 After the 0x0D of group n: prbs_len!=0 -> PAY; prbs_len==0 -> DONE.
REQ-023 PAY: first payload byte follows the last 0x0D with no gap; exactly prbs_len bytes, byte_out=prbs_byte captured on edges where prbs_en=1.
REQ-024 prbs_en SHALL be high only in cycles that capture a payload byte (prbs_len cycles per frame); never in IDLE, HDR-except-last-cycle-before-PAY, or DONE.
REQ-025 After last payload byte -> DONE: byte_valid<=0, done<=1 for one cycle, then IDLE.
REQ-026 start while busy or in DONE SHALL be ignored, no err.
REQ-027 abort=1 in HDR or PAY -> IDLE on that edge, byte_valid<=0, busy<=0, no done, counters cleared; abort in IDLE/DONE ignored; abort has priority over all transitions.
REQ-028 Next frame may start the cycle after DONE (start sampled in IDLE).
REQ-029 Changes on n or prbs_len during a frame SHALL not affect it.

Reset
REQ-030 arst_n=0 SHALL immediately force IDLE, byte_out=0, byte_valid=0, busy=0, done=0, err=0, all counters 0; prbs_en=0 while in reset.
REQ-031 Reset mid-frame SHALL discard the frame; first action after release needs a new start.

Verification
REQ-032 n=2, prbs_len=3, start pulse -> byte_out 0A,0B,0C,0D,0A,0B,0C,0D,P0,P1,P2 on 11 consecutive valid cycles, prbs_en high exactly 3 cycles, done one cycle after P2.
REQ-033 n=0, start -> err high one cycle, byte_valid and busy stay 0.
REQ-034 n=1, prbs_len=0 -> 0A,0B,0C,0D then done next cycle, prbs_en never high.
REQ-035 n=3, abort asserted on the 6th header byte -> byte_valid 0 next cycle, no done, new start then produces full frame from 0x0A.
REQ-036 arst_n low during PAY byte 2 of 5 -> all outputs 0 asynchronously; start held high during frame and DONE produces no second frame until IDLE.

Source files
------------

// File: rtl/prbs_test_ctrl.sv
// ---------------------------------------------------------------------------
// prbs_test_ctrl
//
// Purpose:
//   Builds one test frame per accepted start request and streams it byte by
//   byte towards a pattern detector. A frame is n header groups of the bytes
//   0x0A,0x0B,0x0C,0x0D followed by prbs_len payload bytes taken from an
//   external PRBS-15 generator. The generator is advanced with prbs_en in
//   exactly the cycles whose closing edge captures its current byte.
//
// Ports:
//   clk         in   single clock, all state changes on the rising edge
//   arst_n      in   asynchronous active-low reset
//   start       in   frame request, only looked at while idle
//   abort       in   synchronous abort of a running frame
//   n           in   header group count, latched on an accepted start
//   prbs_len    in   payload byte count, latched on an accepted start
//   prbs_byte   in   current byte of the PRBS generator
//   prbs_en     out  combinational advance/capture strobe for the generator
//   byte_out    out  registered stream byte
//   byte_valid  out  registered, byte_out carries a frame byte
//   busy        out  registered, frame in header or payload phase
//   done        out  registered one-cycle pulse at normal completion
//   err         out  registered one-cycle pulse when start is rejected (n==0)
// ---------------------------------------------------------------------------
module prbs_test_ctrl #(
  parameter int PATT_WIDTH = 8,
  parameter int REP_WIDTH  = 5,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [REP_WIDTH-1:0]  n,
  input  logic [LEN_WIDTH-1:0]  prbs_len,
  input  logic [PATT_WIDTH-1:0] prbs_byte,
  output logic                  prbs_en,
  output logic [PATT_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [PATT_WIDTH-1:0] HDR_BASE = PATT_WIDTH'(8'h0A);
  localparam logic [1:0]            HDR_LAST = 2'd3;

  state_e                state_q, state_d;
  logic [PATT_WIDTH-1:0] byteOut_q, byteOut_d;
  logic                  byteValid_q, byteValid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // hdrIdx/grpCnt describe the header byte currently shown on byte_out;
  // payCnt is the number of payload bytes captured so far in this frame.
  logic [1:0]            hdrIdx_q, hdrIdx_d;
  logic [REP_WIDTH-1:0]  grpCnt_q, grpCnt_d;
  logic [LEN_WIDTH-1:0]  payCnt_q, payCnt_d;
  logic [REP_WIDTH-1:0]  nLat_q, nLat_d;
  logic [LEN_WIDTH-1:0]  lenLat_q, lenLat_d;

  logic                  lastHdrByte;
  logic                  lastPayByte;

  // Comparing the group counter against n-1 lets the counter stay within
  // 0..n-1, so n = 2^REP_WIDTH-1 never needs a wider counter or a wrap.
  assign lastHdrByte = (hdrIdx_q == HDR_LAST) &&
                       (grpCnt_q == (nLat_q - REP_WIDTH'(1)));
  assign lastPayByte = (payCnt_q == lenLat_q);

  // Next-state and output decode. Registered outputs default to their idle
  // values, so every path that leaves a frame only has to set the state.
  always_comb begin
    state_d     = state_q;
    byteOut_d   = '0;
    byteValid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    hdrIdx_d    = '0;
    grpCnt_d    = '0;
    payCnt_d    = '0;
    nLat_d      = nLat_q;
    lenLat_d    = lenLat_q;
    prbs_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (n != '0) begin
            state_d     = HDR;
            nLat_d      = n;
            lenLat_d    = prbs_len;
            byteOut_d   = HDR_BASE;
            byteValid_d = 1'b1;
            busy_d      = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      HDR: begin
        if (abort) begin
          state_d = IDLE;
        end else if (hdrIdx_q != HDR_LAST) begin
          hdrIdx_d    = hdrIdx_q + 2'd1;
          grpCnt_d    = grpCnt_q;
          byteOut_d   = HDR_BASE + PATT_WIDTH'(hdrIdx_q + 2'd1);
          byteValid_d = 1'b1;
          busy_d      = 1'b1;
        end else if (!lastHdrByte) begin
          grpCnt_d    = grpCnt_q + REP_WIDTH'(1);
          byteOut_d   = HDR_BASE;
          byteValid_d = 1'b1;
          busy_d      = 1'b1;
        end else if (lenLat_q != '0) begin
          // The first payload byte is captured on the same edge that
          // retires the last 0x0D, so the stream has no gap.
          state_d     = PAY;
          prbs_en     = 1'b1;
          byteOut_d   = prbs_byte;
          payCnt_d    = LEN_WIDTH'(1);
          byteValid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      PAY: begin
        if (abort) begin
          state_d = IDLE;
        end else if (lastPayByte) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          prbs_en     = 1'b1;
          byteOut_d   = prbs_byte;
          payCnt_d    = payCnt_q + LEN_WIDTH'(1);
          byteValid_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      DONE: begin
        // start and abort are both ignored here; the next frame can be
        // requested in the following IDLE cycle.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset forces the idle picture at once.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      byteOut_q   <= '0;
      byteValid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      hdrIdx_q    <= '0;
      grpCnt_q    <= '0;
      payCnt_q    <= '0;
      nLat_q      <= '0;
      lenLat_q    <= '0;
    end else begin
      state_q     <= state_d;
      byteOut_q   <= byteOut_d;
      byteValid_q <= byteValid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      hdrIdx_q    <= hdrIdx_d;
      grpCnt_q    <= grpCnt_d;
      payCnt_q    <= payCnt_d;
      nLat_q      <= nLat_d;
      lenLat_q    <= lenLat_d;
    end
  end

  assign byte_out   = byteOut_q;
  assign byte_valid = byteValid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
